// File: rtl/run_ctrl_mod14_pkg.sv
// Shared types and constants for the mod-14 run controller and its expected-count tracker.
package run_ctrl_pkg;

    localparam int CNT_W   = 4;
    localparam int MODULUS = 14;
    localparam int MOD_MAX = MODULUS - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_STOP1,
        ST_STOP2,
        ST_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/run_ctrl_mod14_tracker.sv
// Expected-count register: loads a snapshot, then increments with wrap at MODULUS-1.
module mod14_tracker
    import run_ctrl_pkg::*;
#(
    parameter int MODULUS = run_ctrl_pkg::MODULUS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            // Wrap is decided before incrementing, so 14 and 15 are never reached.
            r_count <= (r_count == CNT_W'(MODULUS - 1)) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_ctrl_mod14.sv
// Start/stop initiator for a mod-14 counter: runs it for cmd_len increments and checks the final count.
module run_ctrl_mod14
    import run_ctrl_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int MODULUS     = run_ctrl_pkg::MODULUS,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             start,
    output logic             stop,
    input  logic [CNT_W-1:0] count_in,
    input  logic             stop_d2,
    output logic             busy,
    output logic             done,
    output logic             count_ok,
    output logic             ack_timeout,
    output logic [CNT_W-1:0] result_count
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    state_e           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, r_remaining;
    logic [WAIT_W-1:0] r_wait;
    logic             r_start, r_stop, r_done, r_count_ok, r_ack_timeout;
    logic [CNT_W-1:0] r_result;
    logic [CNT_W-1:0] w_exp;
    logic             w_accept, w_exp_load, w_exp_inc, w_finish_ok, w_finish_to;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    mod14_tracker #(.MODULUS(MODULUS)) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_exp_load),
        .i_load_val (count_in),
        .i_inc      (w_exp_inc),
        .o_count    (w_exp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_exp_load  = 1'b0;
        w_exp_inc   = 1'b0;
        w_finish_ok = 1'b0;
        w_finish_to = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_len == '0) begin
                        w_state_nxt = ST_DONE;
                        w_finish_ok = 1'b1;
                    end else begin
                        w_state_nxt = ST_START;
                    end
                end
            end
            ST_START: begin
                w_exp_load  = 1'b1;
                w_state_nxt = (r_len == LEN_W'(1)) ? ST_STOP1 : ST_RUN;
            end
            ST_RUN: begin
                w_exp_inc = 1'b1;
                if (r_remaining == LEN_W'(1)) w_state_nxt = ST_STOP1;
            end
            // The counter is still enabled on the STOP1 edge: that is the final increment.
            ST_STOP1: begin
                w_exp_inc   = 1'b1;
                w_state_nxt = ST_STOP2;
            end
            ST_STOP2: w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (stop_d2) begin
                    w_state_nxt = ST_DONE;
                    w_finish_ok = (count_in == w_exp);
                end else if (r_wait == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_finish_ok = (count_in == w_exp);
                    w_finish_to = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pulses are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start       <= 1'b0;
            r_stop        <= 1'b0;
            r_done        <= 1'b0;
            r_count_ok    <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_result      <= '0;
            r_len         <= '0;
            r_remaining   <= '0;
            r_wait        <= '0;
        end else begin
            r_start <= (w_state_nxt == ST_START);
            r_stop  <= (w_state_nxt == ST_STOP1) || (w_state_nxt == ST_STOP2);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_accept) r_len <= cmd_len;
            if (r_state == ST_START)    r_remaining <= r_len - LEN_W'(1);
            else if (r_state == ST_RUN) r_remaining <= r_remaining - LEN_W'(1);
            r_wait <= (r_state == ST_CHECK) ? r_wait + WAIT_W'(1) : '0;
            if (w_state_nxt == ST_DONE) begin
                r_result      <= count_in;
                r_count_ok    <= w_finish_ok;
                r_ack_timeout <= w_finish_to;
            end
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign start        = r_start;
    assign stop         = r_stop;
    assign done         = r_done;
    assign count_ok     = r_count_ok;
    assign ack_timeout  = r_ack_timeout;
    assign result_count = r_result;

endmodule
